// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Lets the memory-stage (core) port and the debug/loader port share one
// single-port, synchronous-read data memory. The arbiter issues at most one
// access per cycle. The core port has priority. A starvation counter makes
// sure a pending debug request is granted after at most STARVE_LIMIT losses.
//
// Ports:
//   clk, resetn            clock; asynchronous active-low reset
//   core_req/we/addr/wdata/wcmd -> core_gnt, core_rvalid, core_rdata
//   dbg_req/we/addr/wdata       -> dbg_gnt,  dbg_rvalid,  dbg_rdata
//   stall_pipeline         core request pending but not granted this cycle
//   mem_addr/we/wdata/wcmd memory command for the granted access (zero when idle)
//   mem_rdata              memory read data, valid the cycle after a read issues
module dmem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [1:0]  core_wcmd,
  output logic        core_gnt,
  output logic        core_rvalid,
  output logic [31:0] core_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic        stall_pipeline,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_wcmd,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_CORE = 2'd1,
    RD_DBG  = 2'd2
  } rd_owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic [3:0] starve_cnt_nxt;
  rd_owner_t  rd_owner;
  rd_owner_t  rd_owner_nxt;

  always_comb begin
    dbg_gnt        = dbg_req & (~core_req | (starve_cnt == LIMIT));
    core_gnt       = core_req & ~dbg_gnt;
    stall_pipeline = core_req & ~core_gnt;

    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    mem_wcmd  = 2'b00;
    if (dbg_gnt) begin
      mem_addr  = dbg_addr;
      mem_we    = dbg_we;
      mem_wdata = dbg_wdata;
      mem_wcmd  = 2'b10;
    end else if (core_gnt) begin
      mem_addr  = core_addr;
      mem_we    = core_we;
      mem_wdata = core_wdata;
      mem_wcmd  = core_wcmd;
    end

    // A debug request that is still waiting implies the core won this cycle.
    starve_cnt_nxt = starve_cnt;
    if (!dbg_req || dbg_gnt) begin
      starve_cnt_nxt = '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt_nxt = starve_cnt + 4'd1;
    end

    rd_owner_nxt = RD_NONE;
    if (dbg_gnt && !dbg_we) begin
      rd_owner_nxt = RD_DBG;
    end else if (core_gnt && !core_we) begin
      rd_owner_nxt = RD_CORE;
    end
  end

  assign core_rvalid = (rd_owner == RD_CORE);
  assign dbg_rvalid  = (rd_owner == RD_DBG);

  // The read-data registers sample mem_rdata during the rvalid cycle.
  // They hold that value afterwards.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
      rd_owner   <= RD_NONE;
      core_rdata <= '0;
      dbg_rdata  <= '0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      rd_owner   <= rd_owner_nxt;
      if (rd_owner == RD_CORE) core_rdata <= mem_rdata;
      if (rd_owner == RD_DBG)  dbg_rdata  <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic [1:0]  core_wcmd;
  logic        core_gnt, core_rvalid;
  logic [31:0] core_rdata;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        stall_pipeline;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_wcmd;
  logic [31:0] mem_rdata;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_wcmd(core_wcmd), .core_gnt(core_gnt),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata), .stall_pipeline(stall_pipeline),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_wcmd(mem_wcmd), .mem_rdata(mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive the next cycle's inputs after this returns; check 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0; core_wcmd = 2'b10;
    dbg_req  = 1'b0; dbg_we  = 1'b0; dbg_addr  = '0; dbg_wdata  = '0;
  endtask

  logic [7:0] dpat;

  initial begin
    idle();
    mem_rdata = '0;
    resetn    = 1'b0;

    // Reset with both requests high: the core wins because starve_cnt is held at 0.
    core_req = 1'b1; dbg_req = 1'b1; core_addr = 32'h4; dbg_addr = 32'h8;
    #2;
    check_eq("rst_core_rvalid", core_rvalid, 0);
    check_eq("rst_dbg_rvalid", dbg_rvalid, 0);
    check_eq("rst_core_rdata", core_rdata, 0);
    check_eq("rst_dbg_rdata", dbg_rdata, 0);
    check_eq("rst_core_gnt", core_gnt, 1);
    check_eq("rst_dbg_gnt", dbg_gnt, 0);
    for (int i = 0; i < 6; i++) tick();
    check_eq("rst_hold_dbg_gnt", dbg_gnt, 0);
    check_eq("rst_hold_core_rvalid", core_rvalid, 0);
    idle();
    resetn = 1'b1;
    tick();

    // Core read alone
    core_req = 1'b1; core_addr = 32'h10;
    #1;
    check_eq("cr_gnt", core_gnt, 1);
    check_eq("cr_stall", stall_pipeline, 0);
    check_eq("cr_mem_addr", mem_addr, 32'h10);
    check_eq("cr_mem_we", mem_we, 0);
    tick();
    idle(); mem_rdata = 32'hDEAD_BEEF;
    #1;
    check_eq("cr_rvalid", core_rvalid, 1);
    check_eq("cr_dbg_rvalid", dbg_rvalid, 0);
    check_eq("cr_idle_mem_addr", mem_addr, 0);
    check_eq("cr_idle_mem_wcmd", mem_wcmd, 0);
    tick();
    mem_rdata = 32'h0BAD_0BAD;
    #1;
    check_eq("cr_rvalid_off", core_rvalid, 0);
    check_eq("cr_rdata", core_rdata, 32'hDEAD_BEEF);
    tick();
    check_eq("cr_rdata_hold", core_rdata, 32'hDEAD_BEEF);

    // Starvation: core reads every cycle; the debug read waits four cycles and wins in cycle 4.
    for (int c = 0; c <= 6; c++) begin
      core_req = (c <= 5); core_we = 1'b0; core_addr = 32'h1000 + 32'(c);
      dbg_req = (c <= 4); dbg_we = 1'b0; dbg_addr = 32'h200;
      mem_rdata = 32'hA000_0000 + 32'(c);
      #1;
      check_eq($sformatf("sv_dbg_gnt_c%0d", c), dbg_gnt, (c == 4) ? 1 : 0);
      check_eq($sformatf("sv_core_gnt_c%0d", c), core_gnt, (c <= 5 && c != 4) ? 1 : 0);
      check_eq($sformatf("sv_stall_c%0d", c), stall_pipeline, (c == 4) ? 1 : 0);
      check_eq($sformatf("sv_core_rvalid_c%0d", c), core_rvalid, ((c >= 1 && c <= 4) || c == 6) ? 1 : 0);
      check_eq($sformatf("sv_dbg_rvalid_c%0d", c), dbg_rvalid, (c == 5) ? 1 : 0);
      if (c == 4) check_eq("sv_mem_addr_dbg", mem_addr, 32'h200);
      if (c == 5) check_eq("sv_core_rdata", core_rdata, 32'hA000_0004);
      if (c == 6) check_eq("sv_dbg_rdata", dbg_rdata, 32'hA000_0005);
      tick();
    end
    idle();
    tick();

    // A dropped debug request clears the counter; the reissued request starts from 0.
    dpat = 8'b1111_1011;  // bit i = dbg_req in cycle i
    for (int c = 0; c < 8; c++) begin
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h50;
      dbg_req = dpat[c]; dbg_we = 1'b1; dbg_addr = 32'h60; dbg_wdata = 32'h5;
      #1;
      check_eq($sformatf("drop_dbg_gnt_c%0d", c), dbg_gnt, (c == 7) ? 1 : 0);
      tick();
    end
    idle();
    tick();

    // Debug store with the core idle
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h100; dbg_wdata = 32'h1234_5678;
    #1;
    check_eq("ds_gnt", dbg_gnt, 1);
    check_eq("ds_mem_we", mem_we, 1);
    check_eq("ds_mem_wcmd", mem_wcmd, 2'b10);
    check_eq("ds_mem_addr", mem_addr, 32'h100);
    check_eq("ds_mem_wdata", mem_wdata, 32'h1234_5678);
    tick();
    idle();
    #1;
    check_eq("ds_no_dbg_rvalid", dbg_rvalid, 0);
    check_eq("ds_no_core_rvalid", core_rvalid, 0);
    tick();

    // Alternating reads: core, then debug
    core_req = 1'b1; core_addr = 32'h20;
    tick();
    idle(); dbg_req = 1'b1; dbg_addr = 32'h30; mem_rdata = 32'h1111_1111;
    #1;
    check_eq("alt_dbg_gnt", dbg_gnt, 1);
    check_eq("alt_core_rvalid", core_rvalid, 1);
    check_eq("alt_dbg_rvalid0", dbg_rvalid, 0);
    tick();
    idle(); mem_rdata = 32'h2222_2222;
    #1;
    check_eq("alt_dbg_rvalid", dbg_rvalid, 1);
    check_eq("alt_core_rvalid_off", core_rvalid, 0);
    check_eq("alt_core_rdata", core_rdata, 32'h1111_1111);
    tick();
    mem_rdata = '0;
    #1;
    check_eq("alt_dbg_rdata", dbg_rdata, 32'h2222_2222);
    check_eq("alt_core_rdata_hold", core_rdata, 32'h1111_1111);
    tick();

    // Core half-word stores against a debug read at the starvation limit
    for (int c = 0; c <= 5; c++) begin
      core_req = 1'b1; core_we = 1'b1; core_addr = 32'h40; core_wdata = 32'hBEEF; core_wcmd = 2'b01;
      dbg_req = (c <= 4); dbg_we = 1'b0; dbg_addr = 32'h44;
      #1;
      check_eq($sformatf("cs_dbg_gnt_c%0d", c), dbg_gnt, (c == 4) ? 1 : 0);
      check_eq($sformatf("cs_stall_c%0d", c), stall_pipeline, (c == 4) ? 1 : 0);
      check_eq($sformatf("cs_mem_we_c%0d", c), mem_we, (c == 4) ? 0 : 1);
      check_eq($sformatf("cs_mem_wcmd_c%0d", c), mem_wcmd, (c == 4) ? 2'b10 : 2'b01);
      check_eq($sformatf("cs_core_rvalid_c%0d", c), core_rvalid, 0);
      check_eq($sformatf("cs_dbg_rvalid_c%0d", c), dbg_rvalid, (c == 5) ? 1 : 0);
      tick();
    end
    idle();
    tick();

    // Reset arrives the cycle after a core read grant
    core_req = 1'b1; core_addr = 32'h70; mem_rdata = 32'h7777_7777;
    tick();
    idle();
    resetn = 1'b0;
    #1;
    check_eq("mr_rvalid_in_rst", core_rvalid, 0);
    check_eq("mr_rdata_in_rst", core_rdata, 0);
    #2;
    resetn = 1'b1;
    tick();
    check_eq("mr_rvalid_after", core_rvalid, 0);
    check_eq("mr_rdata_after", core_rdata, 0);
    tick();
    check_eq("mr_rdata_after2", core_rdata, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single-port, synchronous-read data memory between the pipeline's memory stage (core port) and an external debug/loader port. It issues at most one access per cycle and returns read data one cycle after issue. Core accesses have priority; a starvation counter guarantees the debug port forward progress. When a core request is not granted, the block raises a stall to the pipeline registers.

## Interface
Parameters:
- STARVE_LIMIT, 4: maximum number of consecutive cycles a pending debug request can lose to the core (range 1-15).

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- resetn  in  1  asynchronous, active-low reset
- core_req  in  1  core memory access request from the memory stage
- core_we  in  1  core access is a store
- core_addr  in  32  core byte address
- core_wdata  in  32  core store data
- core_wcmd  in  2  core store width: 00 = byte, 01 = half, 10 = word
- core_gnt  out  1  core access issued this cycle
- core_rvalid  out  1  core read data valid
- core_rdata  out  32  core read data
- dbg_req  in  1  debug access request; address, data and we must be held stable until dbg_gnt
- dbg_we  in  1  debug access is a store (always word width)
- dbg_addr  in  32  debug byte address
- dbg_wdata  in  32  debug store data
- dbg_gnt  out  1  debug access issued this cycle
- dbg_rvalid  out  1  debug read data valid
- dbg_rdata  out  32  debug read data
- stall_pipeline  out  1  hold IF/ID, ID/EX and EX/MW; core_req is pending and not granted
- mem_addr  out  32  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  32  memory write data
- mem_wcmd  out  2  memory store width
- mem_rdata  in  32  memory read data, valid the cycle after a read is issued

## Operation
- Grant (combinational from the request inputs and the registered starve_cnt):
  - dbg_gnt = dbg_req & (~core_req | starve_cnt == STARVE_LIMIT)
  - core_gnt = core_req & ~dbg_gnt
  - The two grants are never both 1.
- stall_pipeline = core_req & ~core_gnt.
- Memory mux:
  - dbg_gnt: mem_* driven from dbg_*, with mem_wcmd = 10.
  - core_gnt: mem_* driven from core_*.
  - No grant: mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_wcmd = 00.
- starve_cnt (4-bit register):
  - Cleared when dbg_req = 0 or dbg_gnt = 1.
  - Otherwise incremented (dbg_req & core_gnt).
  - Saturates at STARVE_LIMIT and never wraps.
- Read return tracking:
  - Registered rd_owner (2 bits: none/core/dbg) captures the granted requester when the granted access has we = 0.
  - Otherwise rd_owner captures none.
- Read data return (all registered):
  - core_rvalid = (rd_owner == core).
  - dbg_rvalid = (rd_owner == dbg).
  - core_rdata and dbg_rdata register mem_rdata into the owner's data output only when that owner's rvalid is set; otherwise they hold their value.
  - Return path modelled as an output register sampling mem_rdata in the cycle following issue.
- Writes return no response; the grant cycle is the completion.

## Timing
- Reset (resetn = 0, asynchronous): starve_cnt = 0, rd_owner = none, core_rvalid = 0, dbg_rvalid = 0, core_rdata = 0, dbg_rdata = 0. Combinational outputs follow the inputs with starve_cnt = 0.
- Read latency: rvalid is asserted exactly 1 cycle after the grant cycle, for exactly 1 cycle.
- Back-to-back reads from either port are supported every cycle, including alternating owners.
- Worst-case debug wait: a debug request under continuous core_req is granted in cycle STARVE_LIMIT+1 of its assertion (counting the first cycle as 1). The core stalls that one cycle.
- Debug request dropped before grant: the counter clears, and the next request starts from 0.
- Reset mid-read: the pending rvalid is lost; no rvalid after reset release.
- Simultaneous core store and debug read at the starvation limit: the debug read is issued, stall_pipeline = 1, and the core store is issued the next cycle if still requested.

## Test plan
- Reset: hold resetn = 0 with all requests high -> rvalid = 0, rdata = 0, starve_cnt = 0. Grants follow the rule with starve_cnt = 0 (core wins).
- Core read alone: core_req = 1, addr = 0x0000_0010, mem_rdata = 0xDEAD_BEEF in the next cycle -> core_gnt = 1, stall = 0; core_rvalid = 1 with core_rdata = 0xDEAD_BEEF one cycle later; dbg_rvalid stays 0.
- Starvation, STARVE_LIMIT = 4: core_req held high, dbg read asserted at cycle 0 -> dbg_gnt in cycle 4 with stall_pipeline = 1 that cycle only, core_gnt in cycles 0-3 and 5. dbg_rvalid in cycle 5.
- Debug store, dbg_we = 1, addr = 0x100, data = 0x1234_5678, core idle -> same cycle: mem_we = 1, mem_wcmd = 10, mem_addr = 0x100; no rvalid follows.
- Alternating reads: core read at cycle 0, dbg read at cycle 1 (core idle) -> core_rvalid at cycle 1, dbg_rvalid at cycle 2, each carrying the correct mem_rdata and never crossed.
- Asynchronous reset asserted the cycle after a core read grant -> core_rvalid stays 0 and core_rdata = 0 after reset release.
